// File: rtl/freqs_pkg.sv
// Constants and state encodings shared by band_power_calc and freqs_display.
package freqs_pkg;

    localparam int NUM_BANDS = 10;
    localparam int SAMPLE_W  = 16;
    localparam int OUT_W     = 12;
    localparam int IDX_W     = 4;

    // Largest bar height; scaled energies above this are clipped.
    localparam int BIN_MAX   = 4095;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DUMP  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/band_power_calc_if.sv
// Serial band-sample stream from the filter bank (valid/ready handshake).
interface band_power_calc_if;
    import freqs_pkg::*;

    logic                       band_valid;
    logic [IDX_W-1:0]           band_idx;
    logic signed [SAMPLE_W-1:0] band_sample;
    logic                       band_ready;

    modport master (output band_valid, band_idx, band_sample, input band_ready);
    modport slave  (input band_valid, band_idx, band_sample, output band_ready);
endinterface

// File: rtl/band_sq_unit.sv
// One-stage registered signed squarer; valid and band index travel alongside.
module band_sq_unit
    import freqs_pkg::*;
(
    input  logic                       sample_clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [IDX_W-1:0]           in_idx,
    input  logic signed [SAMPLE_W-1:0] in_sample,
    output logic                       sq_valid,
    output logic [IDX_W-1:0]           sq_idx,
    output logic [2*SAMPLE_W-1:0]      sq_val
);

    logic signed [2*SAMPLE_W-1:0] sample_ext;
    logic signed [2*SAMPLE_W-1:0] prod;

    // Sign-extend before multiplying so the product is the full 32-bit square.
    always_comb begin
        sample_ext = (2*SAMPLE_W)'(in_sample);
        prod       = sample_ext * sample_ext;
    end

    // Square register with pass-through of valid and index.
    always_ff @(posedge sample_clk or negedge rst_n) begin
        if (!rst_n) begin
            sq_valid <= 1'b0;
            sq_idx   <= '0;
            sq_val   <= '0;
        end else begin
            sq_valid <= in_valid;
            sq_idx   <= in_idx;
            sq_val   <= $unsigned(prod);
        end
    end

endmodule

// File: rtl/band_power_calc.sv
// Per-band energy accumulation with periodic snapshot into ten bar heights.
module band_power_calc #(
    parameter int NUM_BANDS = freqs_pkg::NUM_BANDS,
    parameter int SAMPLE_W  = freqs_pkg::SAMPLE_W,
    parameter int ACC_W     = 40,
    parameter int OUT_W     = freqs_pkg::OUT_W,
    parameter int SHIFT     = 20
) (
    input  logic                 sample_clk,
    input  logic                 rst_n,
    band_power_calc_if.slave     bus,
    input  logic                 set_values_flag,
    output logic [OUT_W-1:0]     bin1_out,
    output logic [OUT_W-1:0]     bin2_out,
    output logic [OUT_W-1:0]     bin3_out,
    output logic [OUT_W-1:0]     bin4_out,
    output logic [OUT_W-1:0]     bin5_out,
    output logic [OUT_W-1:0]     bin6_out,
    output logic [OUT_W-1:0]     bin7_out,
    output logic [OUT_W-1:0]     bin8_out,
    output logic [OUT_W-1:0]     bin9_out,
    output logic [OUT_W-1:0]     bin10_out,
    output logic                 update_done,
    output logic                 overrun,
    output logic                 bad_idx
);
    import freqs_pkg::*;

    localparam logic [IDX_W-1:0] NB_IDX    = IDX_W'(NUM_BANDS);
    localparam logic [IDX_W-1:0] LAST_BAND = IDX_W'(NUM_BANDS - 1);
    localparam logic [ACC_W-1:0] CLIP_ACC  = ACC_W'(BIN_MAX);

    state_e                     state_reg, state_next;
    logic [IDX_W-1:0]           cnt_reg, cnt_next;
    logic                       accepted;
    logic                       dump_en;

    logic                       in_valid_reg;
    logic [IDX_W-1:0]           in_idx_reg;
    logic signed [SAMPLE_W-1:0] in_sample_reg;

    logic                       sq_valid;
    logic [IDX_W-1:0]           sq_idx;
    logic [2*SAMPLE_W-1:0]      sq_val;

    assign bus.band_ready = (state_reg == ST_RUN);
    assign update_done    = (state_reg == ST_DONE);
    assign accepted       = bus.band_valid && bus.band_ready;
    assign dump_en        = (state_reg == ST_DUMP);

    // Capture each transferred sample; the squarer works on this copy.
    always_ff @(posedge sample_clk or negedge rst_n) begin
        if (!rst_n) begin
            in_valid_reg  <= 1'b0;
            in_idx_reg    <= '0;
            in_sample_reg <= '0;
        end else begin
            in_valid_reg  <= accepted;
            in_idx_reg    <= bus.band_idx;
            in_sample_reg <= bus.band_sample;
        end
    end

    band_sq_unit u_sq (
        .sample_clk (sample_clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid_reg),
        .in_idx     (in_idx_reg),
        .in_sample  (in_sample_reg),
        .sq_valid   (sq_valid),
        .sq_idx     (sq_idx),
        .sq_val     (sq_val)
    );

    // State and shared drain/dump counter.
    always_ff @(posedge sample_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_RUN;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next state: the drain lasts two cycles so in-flight squares land first.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_RUN: begin
                if (set_values_flag) begin
                    state_next = ST_DRAIN;
                    cnt_next   = '0;
                end
            end
            ST_DRAIN: begin
                if (cnt_reg == IDX_W'(1)) begin
                    state_next = ST_DUMP;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_DUMP: begin
                if (cnt_reg == LAST_BAND) begin
                    state_next = ST_DONE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_DONE: state_next = ST_RUN;
            default: state_next = ST_RUN;
        endcase
    end

    // Sticky error flags: snapshot request while busy, and out-of-range band.
    always_ff @(posedge sample_clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
            bad_idx <= 1'b0;
        end else begin
            if (set_values_flag && (state_reg != ST_RUN))
                overrun <= 1'b1;
            if (accepted && (bus.band_idx >= NB_IDX))
                bad_idx <= 1'b1;
        end
    end

    // One accumulator and one output latch per band. An index >= NUM_BANDS
    // matches no band, so such samples simply vanish.
    for (genvar gi = 0; gi < NUM_BANDS; gi++) begin : g_band
        logic [ACC_W-1:0] acc_reg;
        logic [OUT_W-1:0] bin_reg;
        logic [ACC_W:0]   sum_w;
        logic [ACC_W-1:0] shifted_w;
        logic             sel_dump;

        assign sum_w     = {1'b0, acc_reg} + (ACC_W+1)'(sq_val);
        assign shifted_w = acc_reg >> SHIFT;
        assign sel_dump  = dump_en && (cnt_reg == IDX_W'(gi));

        // Saturating accumulate; cleared in this band's dump cycle.
        always_ff @(posedge sample_clk or negedge rst_n) begin
            if (!rst_n)
                acc_reg <= '0;
            else if (sel_dump)
                acc_reg <= '0;
            else if (sq_valid && (sq_idx == IDX_W'(gi)))
                acc_reg <= sum_w[ACC_W] ? '1 : sum_w[ACC_W-1:0];
        end

        // Latch the scaled, clipped energy when this band is dumped.
        always_ff @(posedge sample_clk or negedge rst_n) begin
            if (!rst_n)
                bin_reg <= '0;
            else if (sel_dump)
                bin_reg <= (shifted_w > CLIP_ACC) ? OUT_W'(BIN_MAX) : shifted_w[OUT_W-1:0];
        end
    end

    assign bin1_out  = g_band[0].bin_reg;
    assign bin2_out  = g_band[1].bin_reg;
    assign bin3_out  = g_band[2].bin_reg;
    assign bin4_out  = g_band[3].bin_reg;
    assign bin5_out  = g_band[4].bin_reg;
    assign bin6_out  = g_band[5].bin_reg;
    assign bin7_out  = g_band[6].bin_reg;
    assign bin8_out  = g_band[7].bin_reg;
    assign bin9_out  = g_band[8].bin_reg;
    assign bin10_out = g_band[9].bin_reg;

endmodule
